// File: rtl/occ_fetch.sv
// Fetches Occ(read_i, k-1) and Occ(read_i, l) plus C(read_i) for one search step and hands the bundle to ex.
// Latency: normal 2*RD_LAT+3, k==0 RD_LAT+2, control step 1 cycle; one step held at a time, stalls on out_ready.
module occ_fetch #(
  parameter int          RD_LAT   = 1,
  parameter logic [11:0] OCC_BASE = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  position_in,
  input  logic [11:0] addr_in,
  input  logic [7:0]  i_in,
  input  logic [7:0]  z_in,
  input  logic [7:0]  k_in,
  input  logic [7:0]  l_in,
  input  logic [7:0]  d_i_in,
  input  logic [1:0]  read_i_in,
  input  logic [31:0] c_table,
  output logic        mem_en,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  position_out,
  output logic [11:0] addr_out,
  output logic [7:0]  i_out,
  output logic [7:0]  z_out,
  output logic [7:0]  k_out,
  output logic [7:0]  l_out,
  output logic [7:0]  d_i_out,
  output logic [1:0]  read_i_out,
  output logic [7:0]  data_1_out,
  output logic [7:0]  data_2_out,
  output logic [7:0]  C_out
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, OUT} state_t;

  localparam logic [7:0] WAIT_INIT = 8'(RD_LAT - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        out_valid_q;
  logic        mem_en_q;
  logic [11:0] mem_addr_q;
  logic [4:0]  position_q;
  logic [11:0] addr_q;
  logic [7:0]  i_q, z_q, k_q, l_q, d_i_q;
  logic [1:0]  read_i_q;
  logic [7:0]  data_1_q, data_2_q, c_q;

  logic        in_fire;
  logic [7:0]  c_d;
  logic [11:0] addr_a_d, addr_b_in_d, addr_b_d;

  function automatic logic [11:0] occ_addr(input logic [1:0] b, input logic [7:0] idx);
    return OCC_BASE + {2'b00, b, idx};
  endfunction

  // OUT counts as idle for acceptance so a new step can enter on the output handshake cycle.
  assign in_ready    = !rst && (state_q == IDLE || state_q == OUT) && (!out_valid_q || out_ready);
  assign in_fire     = in_valid && in_ready;
  assign c_d         = position_in[4] ? 8'h00 : c_table[{read_i_in, 3'b000} +: 8];
  assign addr_a_d    = occ_addr(read_i_in, k_in - 8'd1);
  assign addr_b_in_d = occ_addr(read_i_in, l_in);
  assign addr_b_d    = occ_addr(read_i_q, l_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= 12'd0;
      position_q  <= 5'd0;
      addr_q      <= 12'd0;
      i_q         <= 8'd0;
      z_q         <= 8'd0;
      k_q         <= 8'd0;
      l_q         <= 8'd0;
      d_i_q       <= 8'd0;
      read_i_q    <= 2'd0;
      data_1_q    <= 8'd0;
      data_2_q    <= 8'd0;
      c_q         <= 8'd0;
    end else if (in_fire) begin
      position_q <= position_in;
      addr_q     <= addr_in;
      i_q        <= i_in;
      z_q        <= z_in;
      k_q        <= k_in;
      l_q        <= l_in;
      d_i_q      <= d_i_in;
      read_i_q   <= read_i_in;
      c_q        <= c_d;
      data_1_q   <= 8'd0;
      data_2_q   <= 8'd0;
      if (position_in[4]) begin
        state_q     <= OUT;
        out_valid_q <= 1'b1;
        mem_en_q    <= 1'b0;
        mem_addr_q  <= 12'd0;
      end else if (k_in == 8'd0) begin
        state_q     <= ISSUE_B;
        out_valid_q <= 1'b0;
        mem_en_q    <= 1'b1;
        mem_addr_q  <= addr_b_in_d;
      end else begin
        state_q     <= ISSUE_A;
        out_valid_q <= 1'b0;
        mem_en_q    <= 1'b1;
        mem_addr_q  <= addr_a_d;
      end
    end else begin
      case (state_q)
        ISSUE_A: begin
          mem_en_q   <= 1'b0;
          mem_addr_q <= 12'd0;
          wait_cnt_q <= WAIT_INIT;
          state_q    <= WAIT_A;
        end
        WAIT_A: begin
          if (wait_cnt_q == 8'd0) begin
            data_1_q   <= mem_rdata;
            state_q    <= ISSUE_B;
            mem_en_q   <= 1'b1;
            mem_addr_q <= addr_b_d;
          end else begin
            wait_cnt_q <= wait_cnt_q - 8'd1;
          end
        end
        ISSUE_B: begin
          mem_en_q   <= 1'b0;
          mem_addr_q <= 12'd0;
          wait_cnt_q <= WAIT_INIT;
          state_q    <= WAIT_B;
        end
        WAIT_B: begin
          if (wait_cnt_q == 8'd0) begin
            data_2_q    <= mem_rdata;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 8'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign out_valid    = out_valid_q;
  assign position_out = position_q;
  assign addr_out     = addr_q;
  assign i_out        = i_q;
  assign z_out        = z_q;
  assign k_out        = k_q;
  assign l_out        = l_q;
  assign d_i_out      = d_i_q;
  assign read_i_out   = read_i_q;
  assign data_1_out   = data_1_q;
  assign data_2_out   = data_2_q;
  assign C_out        = c_q;

endmodule

// File: tb/tb_occ_fetch.sv
// Bench for occ_fetch: dut0 with RD_LAT=1/OCC_BASE=0, dut1 with RD_LAT=3/OCC_BASE=0xF80.
module tb_occ_fetch;

  typedef struct {
    logic [4:0]  pos;
    logic [11:0] addr;
    logic [7:0]  i, z, k, l, di;
    logic [1:0]  r;
    logic [7:0]  d1, d2, c;
    int          lat;
    int          nrd;
    logic [11:0] ra, rb;
    bit          want;
    int          exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  logic        rst [2];
  logic        in_valid [2];
  logic        out_ready [2];
  logic [4:0]  pos_i [2];
  logic [11:0] addr_i [2];
  logic [7:0]  i_i [2], z_i [2], k_i [2], l_i [2], di_i [2];
  logic [1:0]  r_i [2];
  logic [31:0] c_table;

  wire         in_ready [2];
  wire         mem_en [2];
  wire         out_valid [2];
  wire [11:0]  mem_addr [2];
  wire [4:0]   pos_o [2];
  wire [11:0]  addr_o [2];
  wire [7:0]   i_o [2], z_o [2], k_o [2], l_o [2], di_o [2];
  wire [1:0]   r_o [2];
  wire [7:0]   d1_o [2], d2_o [2], c_o [2];

  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  logic [7:0] sr0;
  logic [7:0] sr1 [3];

  // Read data is only meaningful RD_LAT cycles after mem_en; otherwise the bus carries junk.
  always @(posedge clk) begin
    sr0    <= mem_en[0] ? mem0[mem_addr[0]] : 8'hEE;
    sr1[0] <= mem_en[1] ? mem1[mem_addr[1]] : 8'hEE;
    sr1[1] <= sr1[0];
    sr1[2] <= sr1[1];
  end

  occ_fetch #(.RD_LAT(1), .OCC_BASE(12'h000)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .position_in(pos_i[0]), .addr_in(addr_i[0]), .i_in(i_i[0]), .z_in(z_i[0]),
    .k_in(k_i[0]), .l_in(l_i[0]), .d_i_in(di_i[0]), .read_i_in(r_i[0]), .c_table(c_table),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(sr0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .position_out(pos_o[0]), .addr_out(addr_o[0]), .i_out(i_o[0]), .z_out(z_o[0]),
    .k_out(k_o[0]), .l_out(l_o[0]), .d_i_out(di_o[0]), .read_i_out(r_o[0]),
    .data_1_out(d1_o[0]), .data_2_out(d2_o[0]), .C_out(c_o[0])
  );

  occ_fetch #(.RD_LAT(3), .OCC_BASE(12'hF80)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .position_in(pos_i[1]), .addr_in(addr_i[1]), .i_in(i_i[1]), .z_in(z_i[1]),
    .k_in(k_i[1]), .l_in(l_i[1]), .d_i_in(di_i[1]), .read_i_in(r_i[1]), .c_table(c_table),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(sr1[2]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .position_out(pos_o[1]), .addr_out(addr_o[1]), .i_out(i_o[1]), .z_out(z_o[1]),
    .k_out(k_o[1]), .l_out(l_o[1]), .d_i_out(di_o[1]), .read_i_out(r_o[1]),
    .data_1_out(d1_o[1]), .data_2_out(d2_o[1]), .C_out(c_o[1])
  );

  vec_t        q0 [$];
  vec_t        q1 [$];
  logic [11:0] a0 [$];
  logic [11:0] a1 [$];
  bit          pres [2];
  vec_t        cur [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic cmp(input int d, input vec_t e, input string tag);
    chk({tag, "_pos"}, d, 32'(pos_o[d]), 32'(e.pos));
    chk({tag, "_addr"}, d, 32'(addr_o[d]), 32'(e.addr));
    chk({tag, "_i"}, d, 32'(i_o[d]), 32'(e.i));
    chk({tag, "_z"}, d, 32'(z_o[d]), 32'(e.z));
    chk({tag, "_k"}, d, 32'(k_o[d]), 32'(e.k));
    chk({tag, "_l"}, d, 32'(l_o[d]), 32'(e.l));
    chk({tag, "_d_i"}, d, 32'(di_o[d]), 32'(e.di));
    chk({tag, "_read_i"}, d, 32'(r_o[d]), 32'(e.r));
    chk({tag, "_data_1"}, d, 32'(d1_o[d]), 32'(e.d1));
    chk({tag, "_data_2"}, d, 32'(d2_o[d]), 32'(e.d2));
    chk({tag, "_C"}, d, 32'(c_o[d]), 32'(e.c));
  endtask

  task automatic mon(input int d);
    vec_t        e;
    logic [11:0] ea;
    int          na, nq;
    if (rst[d]) begin
      pres[d] = 1'b0;
    end else begin
      na = (d == 0) ? a0.size() : a1.size();
      nq = (d == 0) ? q0.size() : q1.size();
      if (mem_en[d]) begin
        chk("rd_while_out", d, 32'(out_valid[d]), 0);
        if (na > 0) begin
          if (d == 0) ea = a0.pop_front();
          else        ea = a1.pop_front();
          chk("mem_addr", d, 32'(mem_addr[d]), 32'(ea));
        end else begin
          chk("spurious_rd", d, 32'(mem_en[d]), 0);
        end
      end else begin
        chk("mem_addr_idle", d, 32'(mem_addr[d]), 0);
      end
      if (out_valid[d]) begin
        if (!pres[d]) begin
          if (nq == 0) begin
            chk("spurious_out", d, 32'(out_valid[d]), 0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            cur[d]  = e;
            pres[d] = 1'b1;
            chk("latency", d, 32'(cyc), 32'(e.exp_cyc));
            cmp(d, e, "out");
          end
        end else begin
          cmp(d, cur[d], "hold");
        end
        if (out_ready[d]) pres[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  function automatic vec_t mk(input logic [4:0] pos, input logic [11:0] a,
                              input logic [7:0] i, input logic [7:0] z, input logic [7:0] k,
                              input logic [7:0] l, input logic [7:0] di, input logic [1:0] r,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] c,
                              input int lat, input int nrd, input logic [11:0] ra, input logic [11:0] rb);
    vec_t v;
    v.pos = pos; v.addr = a; v.i = i; v.z = z; v.k = k; v.l = l; v.di = di; v.r = r;
    v.d1 = d1; v.d2 = d2; v.c = c; v.lat = lat; v.nrd = nrd; v.ra = ra; v.rb = rb;
    v.want = 1'b1; v.exp_cyc = 0;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the rising edge that follows acceptance.
  task automatic send(input int d, input vec_t v, output int waited);
    bit fired;
    int t;
    fired = 1'b0;
    t = 0;
    waited = 0;
    pos_i[d] = v.pos; addr_i[d] = v.addr; i_i[d] = v.i; z_i[d] = v.z;
    k_i[d] = v.k; l_i[d] = v.l; di_i[d] = v.di; r_i[d] = v.r;
    in_valid[d] = 1'b1;
    while (!fired && waited < 40) begin
      @(negedge clk);
      if (in_ready[d]) begin
        fired = 1'b1;
        t = cyc;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    chk("accept", d, 32'(fired), 1);
    if (fired) begin
      v.exp_cyc = t + v.lat;
      if (v.want) begin
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
      end
      if (v.nrd >= 1) begin
        if (d == 0) a0.push_back(v.ra);
        else        a1.push_back(v.ra);
      end
      if (v.nrd >= 2) begin
        if (d == 0) a0.push_back(v.rb);
        else        a1.push_back(v.rb);
      end
    end
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((((d == 0) ? q0.size() : q1.size()) != 0 || out_valid[d]) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", d, 32'(n < 60), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   w;
    int   n;
    for (int a = 0; a < 4096; a++) begin
      mem0[a] = 8'(a * 7 + 1);
      mem1[a] = 8'(a * 13 + 5);
    end
    mem0[12'h204] = 8'h03; mem0[12'h209] = 8'h07; mem0[12'h104] = 8'h2B;
    mem0[12'h0FE] = 8'h44; mem0[12'h0FF] = 8'h55;
    mem0[12'h300] = 8'h66; mem0[12'h302] = 8'h77;
    mem1[12'h289] = 8'h11; mem1[12'h348] = 8'h22;
    mem1[12'hF80] = 8'h33; mem1[12'h080] = 8'h99;
    c_table = 32'h1C140A00;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      pos_i[d] = '0; addr_i[d] = '0; i_i[d] = '0; z_i[d] = '0;
      k_i[d] = '0; l_i[d] = '0; di_i[d] = '0; r_i[d] = '0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, 32'(in_ready[d]), 0);
      chk("rst_out_valid", d, 32'(out_valid[d]), 0);
      chk("rst_mem_en", d, 32'(mem_en[d]), 0);
      chk("rst_position", d, 32'(pos_o[d]), 0);
      chk("rst_data_1", d, 32'(d1_o[d]), 0);
      chk("rst_C", d, 32'(c_o[d]), 0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 0, 32'(in_ready[0]), 1);
    chk("post_rst_in_ready", 1, 32'(in_ready[1]), 1);
    @(posedge clk);
    #1;

    // dut0: normal, k==0, control step
    send(0, mk(5'h01, 12'h123, 8'd3, 8'd1, 8'd5, 8'd9, 8'd2, 2'd2,
               8'h03, 8'h07, 8'h14, 5, 2, 12'h204, 12'h209), w);
    drain(0);
    send(0, mk(5'h02, 12'h0AB, 8'd4, 8'd0, 8'd0, 8'd4, 8'd1, 2'd1,
               8'h00, 8'h2B, 8'h0A, 3, 1, 12'h104, 12'h000), w);
    drain(0);
    send(0, mk(5'h13, 12'hFFF, 8'd8, 8'd2, 8'd7, 8'd8, 8'd3, 2'd3,
               8'h00, 8'h00, 8'h00, 1, 0, 12'h000, 12'h000), w);
    drain(0);

    // dut0: ten-cycle stall with k=l=255, then back-to-back accept on release
    out_ready[0] = 1'b0;
    send(0, mk(5'h04, 12'h555, 8'd9, 8'd9, 8'd255, 8'd255, 8'd6, 2'd0,
               8'h44, 8'h55, 8'h00, 5, 2, 12'h0FE, 12'h0FF), w);
    n = 0;
    while (!out_valid[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_out_valid", 0, 32'(out_valid[0]), 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", 0, 32'(in_ready[0]), 0);
      chk("stall_mem_en", 0, 32'(mem_en[0]), 0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    send(0, mk(5'h05, 12'hAAA, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 2'd3,
               8'h66, 8'h77, 8'h1C, 5, 2, 12'h300, 12'h302), w);
    chk("b2b_accept_wait", 0, 32'(w), 0);
    drain(0);

    // dut1: RD_LAT=3 with address wrap, then k==0
    send(1, mk(5'h06, 12'h321, 8'd10, 8'd3, 8'd10, 8'd200, 8'd5, 2'd3,
               8'h11, 8'h22, 8'h1C, 9, 2, 12'h289, 12'h348), w);
    drain(1);
    send(1, mk(5'h07, 12'h0F0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd0,
               8'h00, 8'h33, 8'h00, 5, 1, 12'hF80, 12'h000), w);
    drain(1);

    // dut1: reset during WAIT_A; the returning read must not reach data_1
    v = mk(5'h08, 12'h111, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 2'd1,
           8'h00, 8'h00, 8'h00, 0, 1, 12'h080, 12'h000);
    v.want = 1'b0;
    send(1, v, w);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 1, 32'(out_valid[1]), 0);
    chk("midrst_mem_en", 1, 32'(mem_en[1]), 0);
    chk("midrst_in_ready", 1, 32'(in_ready[1]), 0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_in_ready", 1, 32'(in_ready[1]), 1);
      chk("after_rst_out_valid", 1, 32'(out_valid[1]), 0);
      chk("after_rst_mem_en", 1, 32'(mem_en[1]), 0);
      chk("after_rst_data_1", 1, 32'(d1_o[1]), 0);
      chk("after_rst_k", 1, 32'(k_o[1]), 0);
      @(posedge clk);
      #1;
    end
    send(1, mk(5'h1F, 12'h7E7, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 2'd2,
               8'h00, 8'h00, 8'h00, 1, 0, 12'h000, 12'h000), w);
    drain(1);

    repeat (3) @(posedge clk);
    #1;
    chk("reads_left", 0, 32'(a0.size()), 0);
    chk("reads_left", 1, 32'(a1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
